// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - byte-command register bridge between UART RX/TX and a local bus
//
// Turns a byte stream into local-bus register accesses and returns one response byte per command:
//   WRITE: CMD_WR, addr, data -> reg_we pulse, responds ACK_BYTE
//   READ : CMD_RD, addr       -> reg_re pulse, responds with reg_rdata
//   other opcodes             -> responds NAK_BYTE
//
// Timeouts:
//   - A stalled command (missing address or data byte) is dropped silently.
//   - A read whose data never arrives responds NAK_BYTE.
//   - Both raise a one-cycle err_timeout pulse.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rx_data, rx_valid, rx_ready     inbound command bytes
//   tx_data, tx_valid, tx_ready     outbound response bytes
//   reg_addr, reg_wdata             local bus address and write data
//   reg_we, reg_re                  local bus write / read strobes (one-cycle pulses)
//   reg_rdata, reg_rvalid           local bus read return
//   busy                            command in progress (any state other than IDLE)
//   err_timeout                     one-cycle pulse on an inter-byte or read timeout
module uart_cmd_bridge #(
    parameter int         TIMEOUT_CYCLES = 500_000,
    parameter logic [7:0] CMD_WR         = 8'h57,
    parameter logic [7:0] CMD_RD         = 8'h52,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] NAK_BYTE       = 8'h45
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rvalid,
    output logic       busy,
    output logic       err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        WAIT_RD,
        SEND
    } state_t;

    state_t        state;
    logic          op_rd;
    logic [CW-1:0] tmo_cnt;
    logic          rx_fire;
    logic          tmo_hit;

    assign rx_ready = rst_n && (state == IDLE || state == GET_ADDR || state == GET_DATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_rd       <= 1'b0;
            tmo_cnt     <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            reg_addr    <= 8'h00;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Strobes are single-cycle; the counter restarts unless a
            // counting state explicitly holds and advances it below.
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;

            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            op_rd <= (rx_data == CMD_RD);
                            state <= GET_ADDR;
                        end else begin
                            tx_data  <= NAK_BYTE;
                            tx_valid <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (rx_fire) begin
                        reg_addr <= rx_data;
                        if (op_rd) begin
                            reg_re <= 1'b1;
                            state  <= BUS_RD;
                        end else begin
                            state  <= GET_DATA;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GET_DATA: begin
                    if (rx_fire) begin
                        reg_wdata <= rx_data;
                        reg_we    <= 1'b1;
                        state     <= BUS_WR;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                BUS_WR: begin
                    tx_data  <= ACK_BYTE;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end

                // Read data cannot be valid in the strobe cycle itself.
                BUS_RD: begin
                    state <= WAIT_RD;
                end

                // Data arriving in the last counted cycle still wins over the timeout.
                WAIT_RD: begin
                    if (reg_rvalid) begin
                        tx_data  <= reg_rdata;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        tx_data     <= NAK_BYTE;
                        tx_valid    <= 1'b1;
                        state       <= SEND;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - self-checking bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic       err_timeout;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_op_t;

    logic [7:0] exp_tx[$];
    bus_op_t    exp_bus[$];

    // Bus read responder: returns resp_data resp_lat cycles after the reg_re cycle.
    logic       resp_en = 1'b1;
    int         resp_lat = 3;
    logic [7:0] resp_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (reg_re && resp_en && rst_n) begin
                repeat (resp_lat) @(posedge clk);
                #1;
                reg_rvalid = 1'b1;
                reg_rdata  = resp_data;
                @(posedge clk);
                #1;
                reg_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard: every TX transfer and bus strobe must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_we && reg_re) chk("we_re_overlap", 1, 0);
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFF);
                    else chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
                if (reg_we || reg_re) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_bus", {reg_we, reg_re, reg_addr}, 32'hFFFF);
                    end else begin
                        bus_op_t e;
                        e = exp_bus.pop_front();
                        chk("bus_we", {31'h0, reg_we}, {31'h0, e.we});
                        chk("bus_addr", {24'h0, reg_addr}, {24'h0, e.addr});
                        if (e.we) chk("bus_wdata", {24'h0, reg_wdata}, {24'h0, e.wdata});
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", 0, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {31'h0, n < 300}, 1);
    endtask

    typedef struct {
        int         nb;
        logic [7:0] b0, b1, b2;
        logic [7:0] rdata;
        logic [7:0] tx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        vecs.push_back('{3, 8'h57, 8'h10, 8'hA5, 8'h00, 8'h4B});
        vecs.push_back('{2, 8'h52, 8'h22, 8'h00, 8'h3C, 8'h3C});
        vecs.push_back('{1, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h45});
        vecs.push_back('{3, 8'h57, 8'h01, 8'h02, 8'h00, 8'h4B});
        vecs.push_back('{2, 8'h52, 8'hFF, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h45});
        vecs.push_back('{3, 8'h57, 8'hFF, 8'hFF, 8'h00, 8'h4B});
        vecs.push_back('{2, 8'h52, 8'h80, 8'h00, 8'hC3, 8'hC3});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", {31'h0, rx_ready}, 0);
        chk("rst_outputs", {tx_valid, tx_data, reg_we, reg_re, reg_addr, reg_wdata, busy, err_timeout}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rx_ready", {31'h0, rx_ready}, 1);

        // Table-driven commands
        foreach (vecs[i]) begin
            resp_data = vecs[i].rdata;
            if (vecs[i].b0 == 8'h57) exp_bus.push_back('{1'b1, vecs[i].b1, vecs[i].b2});
            if (vecs[i].b0 == 8'h52) exp_bus.push_back('{1'b0, vecs[i].b1, 8'h00});
            exp_tx.push_back(vecs[i].tx);
            send_byte(vecs[i].b0);
            if (vecs[i].nb > 1) send_byte(vecs[i].b1);
            if (vecs[i].nb > 2) send_byte(vecs[i].b2);
            wait_done();
        end

        // Write latency: reg_we in N+1, tx_valid in N+2
        exp_bus.push_back('{1'b1, 8'h44, 8'h55});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h44);
        send_byte(8'h55);
        chk("wr_lat_we", {30'h0, reg_we, tx_valid}, 32'h2);
        @(posedge clk);
        #1;
        chk("wr_lat_tx", {30'h0, reg_we, tx_valid}, 32'h1);
        wait_done();

        // Bad opcode latency: NAK valid the cycle after acceptance
        exp_tx.push_back(8'h45);
        send_byte(8'h11);
        chk("nak_lat", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h45});
        wait_done();

        // Inter-byte timeout in GET_DATA
        send_byte(8'h57);
        send_byte(8'h10);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_data_cycles", n, TMO);
        chk("tmo_data_state", {30'h0, busy, rx_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("tmo_data_pulse", {31'h0, err_timeout}, 0);

        // Timeout in GET_ADDR
        send_byte(8'h52);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_addr_cycles", n, TMO);
        chk("tmo_addr_busy", {31'h0, busy}, 0);

        // Read timeout: NAK, late rvalid ignored
        resp_en = 1'b0;
        exp_bus.push_back('{1'b0, 8'h05, 8'h00});
        exp_tx.push_back(8'h45);
        send_byte(8'h52);
        send_byte(8'h05);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_rd_cycles", n, TMO + 1);
        chk("tmo_rd_nak", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h45});
        wait_done();
        reg_rvalid = 1'b1;
        reg_rdata  = 8'h99;
        @(posedge clk);
        #1;
        reg_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_rvalid", {30'h0, busy, tx_valid}, 0);
        resp_en = 1'b1;

        // TX backpressure
        tx_ready = 1'b0;
        exp_bus.push_back('{1'b1, 8'h33, 8'h44});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h33);
        send_byte(8'h44);
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            chk("bp_hold", {22'h0, tx_valid, rx_ready, tx_data}, {22'h0, 1'b1, 1'b0, 8'h4B});
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_single", {30'h0, tx_valid, busy}, 0);
        chk("bp_drained", exp_tx.size(), 0);

        // Reset in GET_DATA aborts the command
        send_byte(8'h57);
        send_byte(8'h77);
        chk("pre_rst_busy", {31'h0, busy}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_outputs", {tx_valid, tx_data, reg_we, reg_re, reg_addr, reg_wdata, busy, err_timeout, rx_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {30'h0, busy, rx_ready}, 32'h1);
        exp_bus.push_back('{1'b1, 8'h78, 8'h9A});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h78);
        send_byte(8'h9A);
        wait_done();
        chk("hold_addr", {16'h0, reg_addr, reg_wdata}, 32'h789A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
